// File: rtl/fft_stage_feeder_if.sv
// rtl/fft_stage_feeder_if.sv - sample stream, operand stream and twiddle tables of one FFT stage feeder
// The slave side is the feeder itself; the master side is its upstream source plus butterfly.
interface fft_stage_feeder_if #(
  parameter int n = 32,
  parameter int N = 8
);
  logic               recv_val;
  logic               recv_rdy;
  logic [n-1:0]       recv_r;
  logic [n-1:0]       recv_c;
  logic [n*N/2-1:0]   tw_r;
  logic [n*N/2-1:0]   tw_c;
  logic               send_val;
  logic               send_rdy;
  logic [n-1:0]       ar;
  logic [n-1:0]       ac;
  logic [n-1:0]       br;
  logic [n-1:0]       bc;
  logic [n-1:0]       wr;
  logic [n-1:0]       wc;
  logic               done;

  modport slave (
    input  recv_val, recv_r, recv_c, tw_r, tw_c, send_rdy,
    output recv_rdy, send_val, ar, ac, br, bc, wr, wc, done
  );

  modport master (
    output recv_val, recv_r, recv_c, tw_r, tw_c, send_rdy,
    input  recv_rdy, send_val, ar, ac, br, bc, wr, wc, done
  );
endinterface

// File: rtl/fft_stage_feeder.sv
// rtl/fft_stage_feeder.sv - single-buffered operand sequencer for one radix-2 FFT stage
// Loads N complex samples, then issues N/2 (a, b, w) butterfly operand sets in stage order.
module fft_stage_feeder #(
  parameter int n = 32,
  parameter int d = 16,
  parameter int N = 8,
  parameter int S = 1
) (
  input  logic             clk,
  input  logic             reset,
  fft_stage_feeder_if.slave bus
);

  localparam int LW = $clog2(N);
  localparam int KW = (N > 2) ? $clog2(N / 2) : 1;
  localparam int SL = $clog2(S);
  localparam int TL = $clog2(N / (2 * S));

  if ((N < 2) || ((N & (N - 1)) != 0) || (S < 1) || (S > N / 2) ||
      ((S & (S - 1)) != 0) || (d < 0) || (d >= n)) begin : g_bad_params
    $error("fft_stage_feeder: illegal parameter combination");
  end

  typedef enum logic [0:0] {
    S_LOAD  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [LW-1:0]    r_load_cnt;
  logic [KW-1:0]    r_issue_cnt;
  logic             r_done;
  logic [2*n-1:0]   r_buf [N];

  logic             w_recv_rdy;
  logic             w_send_val;
  logic             w_load_hs;
  logic             w_issue_hs;
  logic             w_load_last;
  logic             w_issue_last;

  logic [LW-1:0]    w_k;
  logic [LW-1:0]    w_j;
  logic [LW-1:0]    w_g;
  logic [LW-1:0]    w_ia;
  logic [LW-1:0]    w_ib;
  logic [KW-1:0]    w_it;
  logic [2*n-1:0]   w_a;
  logic [2*n-1:0]   w_b;

  // Handshakes depend only on registered state, so rdy/val never see a combinational loop.
  assign w_load_hs    = (r_state == S_LOAD)  && bus.recv_val;
  assign w_issue_hs   = (r_state == S_ISSUE) && bus.send_rdy;
  assign w_load_last  = w_load_hs  && (r_load_cnt  == LW'(N - 1));
  assign w_issue_last = w_issue_hs && (r_issue_cnt == KW'(N / 2 - 1));

  always_comb begin
    w_next_state = r_state;
    w_recv_rdy   = 1'b0;
    w_send_val   = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_recv_rdy = 1'b1;
        if (w_load_last) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_send_val = 1'b1;
        if (w_issue_last) begin
          w_next_state = S_LOAD;
        end
      end
      default: begin
        w_next_state = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_load_cnt  <= '0;
      r_issue_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_issue_last;
      if (w_load_hs) begin
        r_load_cnt <= w_load_last ? '0 : r_load_cnt + 1'b1;
      end
      if (w_issue_hs) begin
        r_issue_cnt <= w_issue_last ? '0 : r_issue_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_hs) begin
      r_buf[r_load_cnt] <= {bus.recv_r, bus.recv_c};
    end
  end

  // Split k into position j within a span and group g; S is a power of two.
  assign w_k  = LW'(r_issue_cnt);
  assign w_j  = w_k & LW'(S - 1);
  assign w_g  = w_k >> SL;
  assign w_ia = (w_g << (SL + 1)) | w_j;
  assign w_ib = w_ia + LW'(S);
  assign w_it = KW'(w_j << TL);

  assign w_a = r_buf[w_ia];
  assign w_b = r_buf[w_ib];

  assign bus.recv_rdy = w_recv_rdy;
  assign bus.send_val = w_send_val;
  assign bus.done     = r_done;
  assign bus.ar = w_send_val ? w_a[2*n-1:n] : '0;
  assign bus.ac = w_send_val ? w_a[n-1:0]   : '0;
  assign bus.br = w_send_val ? w_b[2*n-1:n] : '0;
  assign bus.bc = w_send_val ? w_b[n-1:0]   : '0;
  assign bus.wr = w_send_val ? bus.tw_r[w_it*n +: n] : '0;
  assign bus.wc = w_send_val ? bus.tw_c[w_it*n +: n] : '0;

endmodule

// File: tb/tb_fft_stage_feeder.sv
// tb/tb_fft_stage_feeder.sv - scoreboard bench for fft_stage_feeder at S = 1, 2, 4 in lockstep
// All three instances share stimulus; sel picks which one the checks observe.
module tb_fft_stage_feeder;

  typedef struct packed {
    logic [31:0] ar;
    logic [31:0] ac;
    logic [31:0] br;
    logic [31:0] bc;
    logic [31:0] wr;
    logic [31:0] wc;
  } ops_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tb_recv_val = 1'b0;
  logic         tb_send_rdy = 1'b0;
  logic [31:0]  tb_recv_r = '0;
  logic [31:0]  tb_recv_c = '0;
  logic [127:0] tb_tw_r;
  logic [127:0] tb_tw_c;

  int tests_run = 0;
  int tests_failed = 0;
  int sel = 1;
  ops_t q [$];

  int a_s1 [4] = '{0, 2, 4, 6};
  int b_s1 [4] = '{1, 3, 5, 7};
  int t_s1 [4] = '{0, 0, 0, 0};
  int a_s2 [4] = '{0, 1, 4, 5};
  int b_s2 [4] = '{2, 3, 6, 7};
  int t_s2 [4] = '{0, 2, 0, 2};
  int a_s4 [4] = '{0, 1, 2, 3};
  int b_s4 [4] = '{4, 5, 6, 7};
  int t_s4 [4] = '{0, 1, 2, 3};

  always #5 clk = ~clk;

  fft_stage_feeder_if #(.n(32), .N(8)) if1 ();
  fft_stage_feeder_if #(.n(32), .N(8)) if2 ();
  fft_stage_feeder_if #(.n(32), .N(8)) if4 ();

  assign if1.recv_val = tb_recv_val;
  assign if1.recv_r   = tb_recv_r;
  assign if1.recv_c   = tb_recv_c;
  assign if1.tw_r     = tb_tw_r;
  assign if1.tw_c     = tb_tw_c;
  assign if1.send_rdy = tb_send_rdy;
  assign if2.recv_val = tb_recv_val;
  assign if2.recv_r   = tb_recv_r;
  assign if2.recv_c   = tb_recv_c;
  assign if2.tw_r     = tb_tw_r;
  assign if2.tw_c     = tb_tw_c;
  assign if2.send_rdy = tb_send_rdy;
  assign if4.recv_val = tb_recv_val;
  assign if4.recv_r   = tb_recv_r;
  assign if4.recv_c   = tb_recv_c;
  assign if4.tw_r     = tb_tw_r;
  assign if4.tw_c     = tb_tw_c;
  assign if4.send_rdy = tb_send_rdy;

  fft_stage_feeder #(.n(32), .d(16), .N(8), .S(1)) u_s1 (.clk(clk), .reset(reset), .bus(if1));
  fft_stage_feeder #(.n(32), .d(16), .N(8), .S(2)) u_s2 (.clk(clk), .reset(reset), .bus(if2));
  fft_stage_feeder #(.n(32), .d(16), .N(8), .S(4)) u_s4 (.clk(clk), .reset(reset), .bus(if4));

  ops_t obs;
  logic obs_recv_rdy;
  logic obs_send_val;
  logic obs_done;

  always_comb begin
    obs          = '0;
    obs_recv_rdy = 1'b0;
    obs_send_val = 1'b0;
    obs_done     = 1'b0;
    case (sel)
      1: begin
        obs = {if1.ar, if1.ac, if1.br, if1.bc, if1.wr, if1.wc};
        obs_recv_rdy = if1.recv_rdy; obs_send_val = if1.send_val; obs_done = if1.done;
      end
      2: begin
        obs = {if2.ar, if2.ac, if2.br, if2.bc, if2.wr, if2.wc};
        obs_recv_rdy = if2.recv_rdy; obs_send_val = if2.send_val; obs_done = if2.done;
      end
      default: begin
        obs = {if4.ar, if4.ac, if4.br, if4.bc, if4.wr, if4.wc};
        obs_recv_rdy = if4.recv_rdy; obs_send_val = if4.send_val; obs_done = if4.done;
      end
    endcase
  end

  function automatic logic [31:0] samp_r(input int v);
    return 32'(v << 16);
  endfunction

  function automatic logic [31:0] samp_c(input int v);
    return -(32'(v << 16));
  endfunction

  function automatic logic [31:0] twr(input int t);
    return 32'((t + 1) << 16);
  endfunction

  function automatic logic [31:0] twc(input int t);
    return -(32'((t + 1) << 16));
  endfunction

  task automatic push_expected(input int base);
    ops_t e;
    int a, b, t;
    for (int k = 0; k < 4; k++) begin
      case (sel)
        1:       begin a = a_s1[k]; b = b_s1[k]; t = t_s1[k]; end
        2:       begin a = a_s2[k]; b = b_s2[k]; t = t_s2[k]; end
        default: begin a = a_s4[k]; b = b_s4[k]; t = t_s4[k]; end
      endcase
      e.ar = samp_r(base + a);
      e.ac = samp_c(base + a);
      e.br = samp_r(base + b);
      e.bc = samp_c(base + b);
      e.wr = twr(t);
      e.wc = twc(t);
      q.push_back(e);
    end
  endtask

  task automatic load_frame(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      tests_run++;
      if (obs_recv_rdy !== 1'b1) begin
        tests_failed++;
        $display("FAIL load_rdy sample=%0d got recv_rdy=%b want 1", i, obs_recv_rdy);
      end
      tb_recv_val = 1'b1;
      tb_recv_r   = samp_r(base + i);
      tb_recv_c   = samp_c(base + i);
      @(posedge clk);
    end
  endtask

  task automatic drain(input bit bp, input bit hold_recv);
    int cyc = 0;
    int hs = 0;
    bit rdy;
    bit sv;
    while (hs < 4 && cyc < 60) begin
      @(negedge clk);
      sv = obs_send_val;
      tests_run++;
      if (obs_send_val !== 1'b1 || obs_recv_rdy !== 1'b0 || obs_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL issue_ctrl cyc=%0d got val=%b rdy=%b done=%b want 1 0 0",
                 cyc, obs_send_val, obs_recv_rdy, obs_done);
      end
      tests_run++;
      if (q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_empty cyc=%0d got operands with no expectation", cyc);
      end else if (obs !== q[0]) begin
        tests_failed++;
        $display("FAIL operands hs=%0d got ar=%h ac=%h br=%h bc=%h wr=%h wc=%h want ar=%h ac=%h br=%h bc=%h wr=%h wc=%h",
                 hs, obs.ar, obs.ac, obs.br, obs.bc, obs.wr, obs.wc,
                 q[0].ar, q[0].ac, q[0].br, q[0].bc, q[0].wr, q[0].wc);
      end
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      tb_send_rdy = rdy;
      tb_recv_val = hold_recv;
      @(posedge clk);
      if (rdy && sv) begin
        if (q.size() > 0) void'(q.pop_front());
        hs++;
      end
      cyc++;
    end
    tests_run++;
    if (hs != 4) begin
      tests_failed++;
      $display("FAIL issue_timeout got %0d handshakes want 4", hs);
    end
    @(negedge clk);
    tb_send_rdy = 1'b0;
    tb_recv_val = 1'b0;
    tests_run++;
    if (obs_done !== 1'b1 || obs_recv_rdy !== 1'b1 || obs_send_val !== 1'b0 || obs !== '0) begin
      tests_failed++;
      $display("FAIL done_pulse got done=%b rdy=%b val=%b ops=%h want 1 1 0 0",
               obs_done, obs_recv_rdy, obs_send_val, obs);
    end
    @(negedge clk);
    tests_run++;
    if (obs_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_width got done=%b want 0", obs_done);
    end
    tests_run++;
    if (q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_left got %0d entries want 0", q.size());
    end
  endtask

  task automatic check_idle(input string tag);
    tests_run++;
    if (obs_recv_rdy !== 1'b1 || obs_send_val !== 1'b0 || obs !== '0 || obs_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s sel=%0d got rdy=%b val=%b ops=%h done=%b want 1 0 0 0",
               tag, sel, obs_recv_rdy, obs_send_val, obs, obs_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int s = 1; s <= 4; s = s * 2) begin
        sel = s;
        #1;
        check_idle("reset_idle");
      end
    end
    sel = 1;
  endtask

  task automatic test_stage(input int s, input int base);
    sel = s;
    push_expected(base);
    load_frame(base, 8);
    drain(1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 1;
    push_expected(30);
    load_frame(30, 8);
    drain(1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    sel = 1;
    load_frame(50, 5);
    @(negedge clk);
    tb_recv_val = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_mid_load");
    push_expected(100);
    load_frame(100, 8);
    drain(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_issue();
    sel = 1;
    load_frame(200, 8);
    @(negedge clk);
    tb_recv_val = 1'b0;
    tb_send_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tb_send_rdy = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_idle("reset_mid_issue");
      @(negedge clk);
    end
    push_expected(10);
    load_frame(10, 8);
    drain(1'b0, 1'b0);
  endtask

  initial begin
    for (int t = 0; t < 4; t++) begin
      tb_tw_r[t*32 +: 32] = twr(t);
      tb_tw_c[t*32 +: 32] = twc(t);
    end
    test_reset();
    test_stage(1, 0);
    test_stage(4, 0);
    test_stage(2, 0);
    test_backpressure();
    test_stage(1, 0);
    test_reset_mid_load();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
